// File: rtl/writeback_stage.sv
// Memory-to-writeback stage: registers memory-stage fields, holds RAM read data across stalls,
// extracts byte/halfword/word loads. Optional misaligned-load check via WB_MISALIGN_CHECK_EN.
module writeback_stage #(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_in,
  input  logic         flush_in,
  input  logic         valid_in,
  input  logic [B-1:0] alu_in,
  input  logic [B-1:0] mem_data_in,
  input  logic         reg_write_in,
  input  logic         mem_to_reg_in,
  input  logic [1:0]   load_size_in,
  input  logic         load_unsigned_in,
  input  logic [W-1:0] write_reg_in,
  output logic [B-1:0] wb_data_out,
  output logic [W-1:0] wb_reg_out,
  output logic         wb_en_out,
  output logic         misalign_out
);

  logic         valid_q;
  logic [B-1:0] alu_q;
  logic         reg_write_q;
  logic         mem_to_reg_q;
  logic [1:0]   size_q;
  logic         unsigned_q;
  logic [W-1:0] wreg_q;
  logic [B-1:0] hold_q;
  logic         hold_valid;

  logic [B-1:0] md;
  logic [7:0]   byte_v;
  logic [15:0]  half_v;
  logic [B-1:0] load_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      alu_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      wreg_q       <= '0;
    end else if (flush_in) begin
      valid_q <= 1'b0;
    end else if (!stall_in) begin
      valid_q      <= valid_in;
      alu_q        <= alu_in;
      reg_write_q  <= reg_write_in;
      mem_to_reg_q <= mem_to_reg_in;
      size_q       <= load_size_in;
      unsigned_q   <= load_unsigned_in;
      wreg_q       <= write_reg_in;
    end
  end

  // RAM data is only valid in the first stalled cycle; capture it then and replay until release.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (flush_in || !stall_in) begin
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      hold_q     <= mem_data_in;
      hold_valid <= 1'b1;
    end
  end

  assign md = hold_valid ? hold_q : mem_data_in;

  always_comb begin
    byte_v = md[{alu_q[1:0], 3'b000} +: 8];
    half_v = alu_q[1] ? md[31:16] : md[15:0];
    unique case (size_q)
      2'b00:   load_v = {{(B-8){byte_v[7] & ~unsigned_q}}, byte_v};
      2'b01:   load_v = {{(B-16){half_v[15] & ~unsigned_q}}, half_v};
      default: load_v = md;
    endcase
  end

`ifdef WB_MISALIGN_CHECK_EN
  assign misalign_out = valid_q & mem_to_reg_q &
                        (((size_q == 2'b01) & alu_q[0]) | (size_q[1] & (alu_q[1:0] != 2'b00)));
`else
  assign misalign_out = 1'b0;
`endif

  assign wb_data_out = mem_to_reg_q ? load_v : alu_q;
  assign wb_reg_out  = wreg_q;
  assign wb_en_out   = valid_q & reg_write_q & (wreg_q != '0) & ~misalign_out;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset, stall_in, flush_in, valid_in;
  logic [31:0] alu_in, mem_data_in;
  logic        reg_write_in, mem_to_reg_in, load_unsigned_in;
  logic [1:0]  load_size_in;
  logic [4:0]  write_reg_in;
  logic [31:0] wb_data_out;
  logic [4:0]  wb_reg_out;
  logic        wb_en_out, misalign_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  writeback_stage #(.B(32), .W(5)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .alu_in(alu_in), .mem_data_in(mem_data_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .write_reg_in(write_reg_in), .wb_data_out(wb_data_out),
    .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out), .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic m2r, input logic rw,
                       input logic [1:0] sz, input logic uns, input logic [4:0] wr);
    valid_in = 1'b1; alu_in = a; mem_to_reg_in = m2r; reg_write_in = rw;
    load_size_in = sz; load_unsigned_in = uns; write_reg_in = wr;
  endtask

  // Advance one edge, then present RAM data for the instruction now in the stage.
  task automatic enter(input logic [31:0] ram);
    step();
    mem_data_in = ram;
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0;
    alu_in = 32'h5555_5555; mem_data_in = 32'hAAAA_AAAA;
    reg_write_in = 1'b1; mem_to_reg_in = 1'b1; load_size_in = 2'b10;
    load_unsigned_in = 1'b0; write_reg_in = 5'd3;
    step(); step();
    check("rst_data", wb_data_out, 32'h0);
    check("rst_reg", {27'd0, wb_reg_out}, 32'd0);
    check("rst_en", {31'd0, wb_en_out}, 32'd0);
    check("rst_mis", {31'd0, misalign_out}, 32'd0);
    reset = 1'b0;

    issue(32'h0000_1234, 1'b0, 1'b1, 2'b10, 1'b0, 5'd5);
    enter(32'hFFFF_FFFF);
    check("alu_data", wb_data_out, 32'h0000_1234);
    check("alu_reg", {27'd0, wb_reg_out}, 32'd5);
    check("alu_en", {31'd0, wb_en_out}, 32'd1);

    // back-to-back loads: each result valid exactly one cycle
    issue(32'h0000_0102, 1'b1, 1'b1, 2'b00, 1'b0, 5'd7);
    enter(32'h1280_3456);
    check("lb_s_data", wb_data_out, 32'hFFFF_FF80);
    check("lb_s_en", {31'd0, wb_en_out}, 32'd1);
    issue(32'h0000_0102, 1'b1, 1'b1, 2'b00, 1'b1, 5'd7);
    enter(32'h1280_3456);
    check("lbu_data", wb_data_out, 32'h0000_0080);
    issue(32'h0000_0100, 1'b1, 1'b1, 2'b00, 1'b0, 5'd8);
    enter(32'h1280_3456);
    check("lb_lane0", wb_data_out, 32'h0000_0056);
    issue(32'h0000_0103, 1'b1, 1'b1, 2'b00, 1'b0, 5'd8);
    enter(32'h1280_3456);
    check("lb_lane3", wb_data_out, 32'h0000_0012);

    issue(32'h0000_0202, 1'b1, 1'b1, 2'b01, 1'b0, 5'd10);
    enter(32'h8001_7FFF);
    check("lh_s_data", wb_data_out, 32'hFFFF_8001);
    issue(32'h0000_0202, 1'b1, 1'b1, 2'b01, 1'b1, 5'd10);
    enter(32'h8001_7FFF);
    check("lhu_data", wb_data_out, 32'h0000_8001);
    issue(32'h0000_0200, 1'b1, 1'b1, 2'b01, 1'b0, 5'd10);
    enter(32'h8001_7FFF);
    check("lh_lower", wb_data_out, 32'h0000_7FFF);
    issue(32'h0000_0204, 1'b1, 1'b1, 2'b11, 1'b0, 5'd10);
    enter(32'h8001_7FFF);
    check("size11_word", wb_data_out, 32'h8001_7FFF);

    // stall hold: 3 stall cycles, RAM output changes, outputs frozen for 4 cycles
    issue(32'h0000_0010, 1'b1, 1'b1, 2'b10, 1'b0, 5'd9);
    enter(32'hDEAD_BEEF);
    check("stall_c0_data", wb_data_out, 32'hDEAD_BEEF);
    check("stall_c0_en", {31'd0, wb_en_out}, 32'd1);
    issue(32'h0000_0abc, 1'b0, 1'b1, 2'b10, 1'b0, 5'd11);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enter(32'h0000_0000 + 32'(i));
      check("stall_data", wb_data_out, 32'hDEAD_BEEF);
      check("stall_en", {31'd0, wb_en_out}, 32'd1);
      check("stall_reg", {27'd0, wb_reg_out}, 32'd9);
    end
    stall_in = 1'b0;
    enter(32'h0000_0000);
    check("unstall_data", wb_data_out, 32'h0000_0abc);
    check("unstall_reg", {27'd0, wb_reg_out}, 32'd11);

    // flush with simultaneous stall
    issue(32'h0000_0055, 1'b0, 1'b1, 2'b10, 1'b0, 5'd4);
    flush_in = 1'b1; stall_in = 1'b1;
    enter(32'h0);
    check("flush_en", {31'd0, wb_en_out}, 32'd0);
    flush_in = 1'b0; stall_in = 1'b0;

    issue(32'h0000_0077, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0);
    enter(32'h0);
    check("r0_en", {31'd0, wb_en_out}, 32'd0);
    check("r0_data", wb_data_out, 32'h0000_0077);

    valid_in = 1'b0;
    alu_in = 32'h0000_0078; write_reg_in = 5'd12; mem_to_reg_in = 1'b0;
    enter(32'h0);
    check("bubble_en", {31'd0, wb_en_out}, 32'd0);

    // misaligned word load
    issue(32'h0000_0101, 1'b1, 1'b1, 2'b10, 1'b0, 5'd6);
    enter(32'hCAFE_F00D);
`ifdef WB_MISALIGN_CHECK_EN
    check("mis_flag", {31'd0, misalign_out}, 32'd1);
    check("mis_en", {31'd0, wb_en_out}, 32'd0);
`else
    check("mis_flag", {31'd0, misalign_out}, 32'd0);
    check("mis_en", {31'd0, wb_en_out}, 32'd1);
    check("mis_data", wb_data_out, 32'hCAFE_F00D);
`endif

    // reset during stall discards held data
    issue(32'h0000_0020, 1'b1, 1'b1, 2'b10, 1'b0, 5'd13);
    enter(32'h1111_2222);
    stall_in = 1'b1;
    enter(32'h3333_4444);
    check("pre_rst_data", wb_data_out, 32'h1111_2222);
    reset = 1'b1;
    enter(32'h5555_6666);
    check("mid_rst_data", wb_data_out, 32'h0);
    check("mid_rst_en", {31'd0, wb_en_out}, 32'd0);
    reset = 1'b0; stall_in = 1'b0; valid_in = 1'b0;
    enter(32'h7777_8888);
    check("post_rst_en", {31'd0, wb_en_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
